// File: rtl/uart_pkg.sv
// Shared constants and types for the UART transmit path.
package uart_pkg;

  localparam int UART_DATA_W  = 8;
  // Baud divider constant for a 27 MHz clock at 115200 baud.
  localparam int UART_CLK_DIV = 233;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    WAIT = 2'd2
  } uart_txq_state_t;

endpackage

// File: rtl/uart_sync_fifo.sv
// Circular byte buffer with a separate level counter and a sticky overflow flag.
module uart_sync_fifo
  import uart_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int LVL_W = $clog2(DEPTH) + 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic [UART_DATA_W-1:0] push_data,
  input  logic                   pop,
  output logic [UART_DATA_W-1:0] pop_data,
  input  logic                   ovf_clr,
  output logic                   full,
  output logic                   empty,
  output logic [LVL_W-1:0]       level,
  output logic                   overflow
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [LVL_W-1:0] FULL_LVL = LVL_W'(DEPTH);

  logic [UART_DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]       wr_ptr;
  logic [PTR_W-1:0]       rd_ptr;
  logic                   push_ok;
  logic                   pop_ok;

  // full is the registered level, so a same-cycle pop never rescues a write.
  assign full     = (level == FULL_LVL);
  assign empty    = (level == '0);
  assign push_ok  = push && !full;
  assign pop_ok   = pop && !empty;
  assign pop_data = mem[rd_ptr];

  // NOTE: the storage array has no reset; stale contents are unreachable
  // because level gates every read, and leaving it unreset keeps it in RAM.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= push_data;
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      level    <= '0;
      overflow <= 1'b0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;

      case ({push_ok, pop_ok})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase

      // A dropped write outranks a coincident clear.
      if (push && full)  overflow <= 1'b1;
      else if (ovf_clr)  overflow <= 1'b0;
    end
  end

endmodule

// File: rtl/uart_tx_fifo.sv
// Byte queue feeding uart_tx through its start/busy handshake, one byte at a time.
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int LVL_W = $clog2(DEPTH) + 1
) (
  input  logic                   uart_clk,
  input  logic                   uart_rst,
  input  logic                   wr_en,
  input  logic [UART_DATA_W-1:0] wr_data,
  input  logic                   ovf_clr,
  output logic                   full,
  output logic                   empty,
  output logic [LVL_W-1:0]       level,
  output logic                   overflow,
  output logic                   idle,
  output logic                   uart_tx_start,
  output logic [UART_DATA_W-1:0] uart_tx_data,
  input  logic                   uart_tx_busy
);

  uart_txq_state_t        state;
  logic                   pop;
  logic [UART_DATA_W-1:0] head;

  uart_sync_fifo #(
    .DEPTH (DEPTH),
    .LVL_W (LVL_W)
  ) u_fifo (
    .clk       (uart_clk),
    .rst       (uart_rst),
    .push      (wr_en),
    .push_data (wr_data),
    .pop       (pop),
    .pop_data  (head),
    .ovf_clr   (ovf_clr),
    .full      (full),
    .empty     (empty),
    .level     (level),
    .overflow  (overflow)
  );

  assign pop  = (state == IDLE) && !empty && !uart_tx_busy;
  assign idle = (state == IDLE) && empty;

  always_ff @(posedge uart_clk or posedge uart_rst) begin
    if (uart_rst) begin
      state         <= IDLE;
      uart_tx_start <= 1'b0;
      uart_tx_data  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (pop) begin
            uart_tx_start <= 1'b1;
            uart_tx_data  <= head;
            state         <= LOAD;
          end
        end
        // Start is held until uart_tx acknowledges it by raising busy.
        LOAD: begin
          if (uart_tx_busy) begin
            uart_tx_start <= 1'b0;
            state         <= WAIT;
          end
        end
        WAIT: begin
          if (!uart_tx_busy) state <= IDLE;
        end
        default: begin
          uart_tx_start <= 1'b0;
          state         <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Scoreboard bench for uart_tx_fifo with a simple uart_tx busy model.
module tb_uart_tx_fifo;

  localparam int DEPTH = 16;
  localparam int LVL_W = $clog2(DEPTH) + 1;

  logic             clk;
  logic             rst;
  logic             wr_en;
  logic [7:0]       wr_data;
  logic             ovf_clr;
  logic             full;
  logic             empty;
  logic [LVL_W-1:0] level;
  logic             overflow;
  logic             idle;
  logic             start;
  logic [7:0]       data;
  logic             busy;

  logic             force_busy;
  logic             model_en;
  logic             model_busy;
  int               model_cnt;

  int               checks;
  int               errors;
  int               pulses;
  logic [7:0]       exp_q[$];
  logic             prev_start;
  logic [7:0]       prev_data;

  uart_tx_fifo #(
    .DEPTH (DEPTH)
  ) dut (
    .uart_clk      (clk),
    .uart_rst      (rst),
    .wr_en         (wr_en),
    .wr_data       (wr_data),
    .ovf_clr       (ovf_clr),
    .full          (full),
    .empty         (empty),
    .level         (level),
    .overflow      (overflow),
    .idle          (idle),
    .uart_tx_start (start),
    .uart_tx_data  (data),
    .uart_tx_busy  (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign busy = model_busy | force_busy;

  // uart_tx model: sees start on an edge, then holds busy for 10 cycles.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      model_busy <= 1'b0;
      model_cnt  <= 0;
    end else if (model_cnt != 0) begin
      model_cnt <= model_cnt - 1;
      if (model_cnt == 1) model_busy <= 1'b0;
    end else if (model_en && start && !model_busy) begin
      model_busy <= 1'b1;
      model_cnt  <= 10;
    end
  end

  // Output monitor: pops the scoreboard on each start rise, and checks data stability.
  always @(negedge clk) begin
    if (start && !prev_start) begin
      pulses++;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL start_pulse_unexpected data=%02h expected=none", data);
      end else begin
        logic [7:0] exp_b;
        exp_b = exp_q.pop_front();
        if (data !== exp_b) begin
          errors++;
          $display("FAIL tx_data_order got=%02h expected=%02h", data, exp_b);
        end
      end
    end else if (start && prev_start) begin
      checks++;
      if (data !== prev_data) begin
        errors++;
        $display("FAIL tx_data_stable got=%02h expected=%02h", data, prev_data);
      end
    end
    prev_start <= start;
    prev_data  <= data;
  end

  task automatic push_byte(input logic [7:0] b, input bit expect_sent);
    if (expect_sent) exp_q.push_back(b);
    wr_en   = 1'b1;
    wr_data = b;
    @(negedge clk);
    wr_en   = 1'b0;
  endtask

  task automatic wait_idle(input int budget, input string name);
    int n;
    n = 0;
    while (!(idle && !busy && exp_q.size() == 0) && n < budget) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n >= budget) begin
      errors++;
      $display("FAIL %s_drain_timeout idle=%0b left=%0d expected idle=1 left=0",
               name, idle, exp_q.size());
    end
  endtask

  task automatic test_reset();
    checks++;
    if ({start, data, full, empty, level, overflow, idle} !==
        {1'b0, 8'h00, 1'b0, 1'b1, {LVL_W{1'b0}}, 1'b0, 1'b1}) begin
      errors++;
      $display("FAIL reset_values start=%0b data=%02h full=%0b empty=%0b level=%0d ovf=%0b idle=%0b expected 0 00 0 1 0 0 1",
               start, data, full, empty, level, overflow, idle);
    end
  endtask

  task automatic test_latency();
    int n;
    push_byte(8'h48, 1'b1);
    checks++;
    if (level !== 5'd1 || start !== 1'b0) begin
      errors++;
      $display("FAIL latency_after_push level=%0d start=%0b expected level=1 start=0", level, start);
    end
    @(negedge clk);
    checks++;
    if (start !== 1'b1 || data !== 8'h48 || level !== 5'd0) begin
      errors++;
      $display("FAIL latency_start start=%0b data=%02h level=%0d expected 1 48 0", start, data, level);
    end
    n = 0;
    while (!busy && n < 20) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (!busy || start !== 1'b1) begin
      errors++;
      $display("FAIL start_held_until_busy busy=%0b start=%0b expected busy=1 start=1", busy, start);
    end
    @(negedge clk);
    checks++;
    if (start !== 1'b0) begin
      errors++;
      $display("FAIL start_falls_after_busy start=%0b expected 0", start);
    end
    n = 0;
    while (busy && n < 30) begin
      checks++;
      if (idle !== 1'b0) begin
        errors++;
        $display("FAIL idle_while_busy idle=%0b expected 0", idle);
      end
      @(negedge clk);
      n++;
    end
    checks++;
    if (idle !== 1'b0) begin
      errors++;
      $display("FAIL idle_in_wait idle=%0b expected 0", idle);
    end
    @(negedge clk);
    checks++;
    if (idle !== 1'b1) begin
      errors++;
      $display("FAIL idle_return idle=%0b expected 1", idle);
    end
  endtask

  task automatic test_burst();
    logic [7:0] hello [7];
    int peak;
    int p0;
    hello = '{8'h48, 8'h65, 8'h6c, 8'h6c, 8'h6f, 8'h0d, 8'h0a};
    peak = 0;
    p0 = pulses;
    for (int i = 0; i < 7; i++) begin
      push_byte(hello[i], 1'b1);
      if (int'(level) > peak) peak = int'(level);
    end
    checks++;
    if (peak != 6) begin
      errors++;
      $display("FAIL burst_level_peak got=%0d expected=6", peak);
    end
    wait_idle(2000, "burst");
    checks++;
    if (pulses - p0 != 7) begin
      errors++;
      $display("FAIL burst_pulse_count got=%0d expected=7", pulses - p0);
    end
  endtask

  task automatic test_overflow();
    int p0;
    p0 = pulses;
    force_busy = 1'b1;
    for (int i = 0; i < DEPTH; i++) push_byte(8'(8'h80 + i), 1'b1);
    checks++;
    if (full !== 1'b1 || level !== 5'd16 || overflow !== 1'b0) begin
      errors++;
      $display("FAIL full_after_16 full=%0b level=%0d ovf=%0b expected 1 16 0", full, level, overflow);
    end
    push_byte(8'hEE, 1'b0);
    checks++;
    if (overflow !== 1'b1 || level !== 5'd16 || full !== 1'b1) begin
      errors++;
      $display("FAIL overflow_drop ovf=%0b level=%0d full=%0b expected 1 16 1", overflow, level, full);
    end
    force_busy = 1'b0;
    wait_idle(2000, "overflow");
    checks++;
    if (pulses - p0 != DEPTH) begin
      errors++;
      $display("FAIL overflow_drain_count got=%0d expected=%0d", pulses - p0, DEPTH);
    end
    ovf_clr = 1'b1;
    @(negedge clk);
    ovf_clr = 1'b0;
  endtask

  task automatic test_same_cycle();
    force_busy = 1'b1;
    for (int i = 0; i < 3; i++) push_byte(8'(8'h30 + i), 1'b1);
    checks++;
    if (level !== 5'd3) begin
      errors++;
      $display("FAIL same_cycle_setup level=%0d expected=3", level);
    end
    force_busy = 1'b0;
    push_byte(8'h33, 1'b1);
    checks++;
    if (level !== 5'd3 || start !== 1'b1) begin
      errors++;
      $display("FAIL push_pop_level level=%0d start=%0b expected level=3 start=1", level, start);
    end
    wait_idle(1000, "same_cycle");
  endtask

  task automatic test_wrap();
    for (int b = 0; b < 4; b++) begin
      for (int i = 0; i < 10; i++) push_byte(8'($urandom_range(0, 255)), 1'b1);
      wait_idle(2000, "wrap");
    end
  endtask

  task automatic test_reset_mid();
    int p0;
    model_en = 1'b0;
    for (int i = 0; i < 6; i++) push_byte(8'(8'hA0 + i), 1'b1);
    checks++;
    if (level !== 5'd5 || start !== 1'b1) begin
      errors++;
      $display("FAIL load_setup level=%0d start=%0b expected level=5 start=1", level, start);
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({start, data, full, empty, level, overflow, idle} !==
        {1'b0, 8'h00, 1'b0, 1'b1, {LVL_W{1'b0}}, 1'b0, 1'b1}) begin
      errors++;
      $display("FAIL async_reset start=%0b data=%02h full=%0b empty=%0b level=%0d ovf=%0b idle=%0b expected 0 00 0 1 0 0 1",
               start, data, full, empty, level, overflow, idle);
    end
    exp_q.delete();
    @(negedge clk);
    rst = 1'b0;
    model_en = 1'b1;
    p0 = pulses;
    repeat (30) @(negedge clk);
    checks++;
    if (pulses != p0 || start !== 1'b0) begin
      errors++;
      $display("FAIL no_start_after_reset pulses=%0d start=%0b expected pulses=0 start=0", pulses - p0, start);
    end
    push_byte(8'h5A, 1'b1);
    wait_idle(1000, "after_reset");
  endtask

  task automatic test_ovf_clr();
    force_busy = 1'b1;
    for (int i = 0; i < DEPTH; i++) push_byte(8'(8'h10 + i), 1'b1);
    push_byte(8'hFF, 1'b0);
    checks++;
    if (overflow !== 1'b1) begin
      errors++;
      $display("FAIL ovf_set got=%0b expected=1", overflow);
    end
    ovf_clr = 1'b1;
    @(negedge clk);
    ovf_clr = 1'b0;
    checks++;
    if (overflow !== 1'b0) begin
      errors++;
      $display("FAIL ovf_clr got=%0b expected=0", overflow);
    end
    ovf_clr = 1'b1;
    push_byte(8'hFE, 1'b0);
    ovf_clr = 1'b0;
    checks++;
    if (overflow !== 1'b1 || level !== 5'd16) begin
      errors++;
      $display("FAIL ovf_set_wins ovf=%0b level=%0d expected ovf=1 level=16", overflow, level);
    end
    force_busy = 1'b0;
    wait_idle(2000, "ovf_clr");
  endtask

  initial begin
    checks     = 0;
    errors     = 0;
    pulses     = 0;
    prev_start = 1'b0;
    prev_data  = 8'h00;
    rst        = 1'b0;
    wr_en      = 1'b0;
    wr_data    = 8'h00;
    ovf_clr    = 1'b0;
    force_busy = 1'b0;
    model_en   = 1'b1;
    #1 rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;

    test_reset();
    test_latency();
    test_burst();
    test_overflow();
    test_same_cycle();
    test_wrap();
    test_reset_mid();
    test_ovf_clr();

    repeat (5) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_tx_fifo.md
# uart_tx_fifo

Byte queue and transmit sequencer between any byte producer (message printer, hex formatter, rx echo path) and `uart_tx`. Producers push bytes at clock rate with a single-cycle write strobe. The block drains them one at a time into `uart_tx` using that core's start/busy handshake. This removes per-byte handshaking from every producer and lets a full message be queued in a burst.

## Interface
Parameters:
- `DEPTH`, 16: FIFO entries. Must be a power of two, at least 2.
- `LVL_W`, $clog2(DEPTH)+1: width of `level`. Derived; do not override.

Ports:
- `uart_clk` in 1: the single clock.
- `uart_rst` in 1: asynchronous, active-high reset.
- `wr_en` in 1: push `wr_data` this cycle.
- `wr_data` in 8: byte to queue.
- `ovf_clr` in 1: clears `overflow`.
- `full` out 1: level == DEPTH.
- `empty` out 1: level == 0.
- `level` out LVL_W: entries currently stored (0..DEPTH).
- `overflow` out 1: sticky; set by a dropped write.
- `idle` out 1: FIFO empty and FSM in IDLE (everything sent).
- `uart_tx_start` out 1: start request to `uart_tx`.
- `uart_tx_data` out 8: byte presented to `uart_tx`.
- `uart_tx_busy` in 1: busy flag from `uart_tx`.

## Operation
- Storage is a circular buffer with read/write pointers of width $clog2(DEPTH). Pointers wrap modulo DEPTH. `level` is a separate counter, which keeps full and empty unambiguous.
- Write: when `wr_en` is high and `full` is low, store the byte at the write pointer, then increment the pointer.
- Write while `full` is high (full sampled before any same-cycle pop): the byte is dropped, the write pointer is unchanged, and `overflow` is set.
- If `ovf_clr` and a dropped write occur in the same cycle, the set wins.
- Pop: happens only on the FSM transition IDLE→LOAD. The head byte is registered into `uart_tx_data` and the read pointer increments.
- A write and a pop in the same cycle leave `level` unchanged.
- FSM has three states:
  - IDLE: `uart_tx_start` = 0. If `!empty` and `!uart_tx_busy`, pop, set `uart_tx_start` = 1, and go to LOAD.
  - LOAD: hold `uart_tx_start` high and `uart_tx_data` stable. When `uart_tx_busy` = 1, drop `uart_tx_start` and go to WAIT.
  - WAIT: when `uart_tx_busy` = 0, go to IDLE.
- `uart_tx_data` changes only on a pop. It holds the last byte sent otherwise.
- Reset mid-frame: all state clears immediately and queued bytes are lost. An in-flight `uart_tx` frame is that core's concern; this block does not wait for it.

## Timing
- Reset values:
  - `uart_tx_start` = 0, `uart_tx_data` = 8'h00
  - `full` = 0, `empty` = 1, `level` = 0
  - `overflow` = 0, `idle` = 1
  - FSM = IDLE, pointers = 0
- Write-to-start latency into an empty, idle block: `wr_en` at edge N, `level` = 1 after N, pop and `uart_tx_start` = 1 after N+1, `level` = 0 after N+1. Two cycles total.
- `uart_tx_start` stays high for at least one cycle and until the first cycle `uart_tx_busy` is seen high. It falls on the edge after busy is sampled high.
- Back-to-back bytes: the next pop occurs on the first edge where the FSM is in IDLE with busy low. That is at least two cycles after busy falls (WAIT→IDLE, then IDLE→LOAD).
- `full`, `empty`, `level` and `idle` are registered or derived from registered state only. There is no combinational path from `wr_en` to them.

## Structure
- Shared package `uart_pkg`:
  - `UART_DATA_W` = 8
  - the FSM state enum `uart_txq_state_t` (IDLE, LOAD, WAIT)
  - the divider constant for 27 MHz / 115200, which is 233
- One sub-module, `uart_sync_fifo`: storage array, pointers, level counter and overflow flag. Its ports are push/pop/data/flags.
- `uart_tx_fifo` holds the FSM and the output registers.

## Test plan
- Reset then push 8'h48 at cycle 0, with a `uart_tx` model that raises busy for 10 cycles one cycle after start → `uart_tx_start` high at cycle 2 with data 8'h48. Start falls the cycle after busy rises. `idle` returns to 1 after busy falls.
- Burst-push "Hello\r\n" (7 bytes) in consecutive cycles → `level` peaks at 6. The bytes appear on `uart_tx_data` in order. There are exactly 7 start pulses and no data change while start is high.
- DEPTH=16: push 17 bytes while busy is forced high → `full` = 1 after 16 bytes. The 17th byte is dropped and `overflow` = 1. Releasing busy drains exactly 16 bytes.
- Push on the same cycle as a pop with `level` = 3 → `level` stays 3. Pointer wrap is checked by pushing 40 bytes in total through DEPTH=16 with a matching byte order.
- Assert `uart_rst` while in LOAD with 5 bytes queued → outputs return to reset values asynchronously. No further start pulses occur until a new push.
- `ovf_clr` pulse → `overflow` = 0. `ovf_clr` coincident with a dropped write → `overflow` stays 1.
